// File: rtl/tomasulo_pkg.sv
// Shared constants and types for the Tomasulo issue unit: opcodes, instruction
// field positions, the "value ready" tag and the issue FSM state encoding.
package tomasulo_pkg;

  localparam int IR_W      = 13;  // bits [15:13] of the queue word carry nothing
  localparam int REG_IDX_W = 3;
  localparam int N_REGS    = 1 << REG_IDX_W;
  localparam int OP_W      = 4;

  localparam int RD_LSB = 10;
  localparam int RS_LSB = 7;
  localparam int RT_LSB = 4;
  localparam int OP_LSB = 0;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OP_W-1:0] OP_MUL = 4'b0100;

  localparam int TAG_NONE = 0;

  typedef enum logic [1:0] {
    S_REQ,
    S_CAP,
    S_ISSUE
  } state_e;

endpackage

// File: rtl/reg_status_table.sv
// Architectural register file plus per-register producer tag (Qi), with CDB
// write-back and a rename port; a rename in the same cycle wins over the CDB clear.
module reg_status_table
  import tomasulo_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [REG_IDX_W-1:0] rs_idx_i,
  input  logic [REG_IDX_W-1:0] rt_idx_i,
  output logic [DATA_W-1:0]    rs_val_o,
  output logic [TAG_W-1:0]     rs_tag_o,
  output logic [DATA_W-1:0]    rt_val_o,
  output logic [TAG_W-1:0]     rt_tag_o,
  input  logic                 cdb_hit_i,
  input  logic [TAG_W-1:0]     cdb_tag_i,
  input  logic [DATA_W-1:0]    cdb_data_i,
  input  logic                 rename_en_i,
  input  logic [REG_IDX_W-1:0] rename_idx_i,
  input  logic [TAG_W-1:0]     rename_tag_i
);

  logic [DATA_W-1:0] regs_q [N_REGS];
  logic [TAG_W-1:0]  qi_q   [N_REGS];

  // NOTE: this array is reset element by element because R[i]=i is architectural
  // state software relies on; plain storage arrays are normally left unreset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_REGS; i++) begin
        regs_q[i] <= DATA_W'(i);
        qi_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_REGS; i++) begin
        if (cdb_hit_i && (qi_q[i] == cdb_tag_i)) begin
          regs_q[i] <= cdb_data_i;
          qi_q[i]   <= '0;
        end
      end
      if (rename_en_i) begin
        qi_q[rename_idx_i] <= rename_tag_i;
      end
    end
  end

  // Reads see pre-write state, so a source equal to rd picks up the old tag.
  assign rs_val_o = regs_q[rs_idx_i];
  assign rs_tag_o = qi_q[rs_idx_i];
  assign rt_val_o = regs_q[rt_idx_i];
  assign rt_tag_o = qi_q[rt_idx_i];

endmodule

// File: rtl/tomasulo_issue_unit.sv
// Tomasulo issue stage: fetches one word from the instruction queue, renames rd,
// allocates a reservation station and emits a registered dispatch packet.
// Define ISSUE_CDB_BYPASS_EN to forward a same-cycle CDB result into operands and
// into the station-free check.
module tomasulo_issue_unit
  import tomasulo_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int N_ADD_RS = 3,
  parameter int N_MUL_RS = 2,
  parameter int TAG_W    = 3
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              enable_in,
  input  logic [15:0]       instruction_in,
  output logic              avaliable,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              disp_valid,
  output logic [TAG_W-1:0]  disp_tag,
  output logic [OP_W-1:0]   disp_op,
  output logic [DATA_W-1:0] disp_vj,
  output logic [DATA_W-1:0] disp_vk,
  output logic [TAG_W-1:0]  disp_qj,
  output logic [TAG_W-1:0]  disp_qk,
  output logic              stall
);

  localparam int               N_RS  = N_ADD_RS + N_MUL_RS;
  localparam logic [TAG_W-1:0] TAG_0 = TAG_W'(TAG_NONE);

`ifdef ISSUE_CDB_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  state_e            state_q;
  logic [IR_W-1:0]   ir_q;
  logic              avaliable_q;
  logic              disp_valid_q;
  logic [TAG_W-1:0]  disp_tag_q, disp_qj_q, disp_qk_q;
  logic [OP_W-1:0]   disp_op_q;
  logic [DATA_W-1:0] disp_vj_q, disp_vk_q;
  logic [N_RS-1:0]   busy_q, busy_d;

  logic unused_ir_hi;
  assign unused_ir_hi = ^instruction_in[15:IR_W];

  logic [OP_W-1:0]      op;
  logic [REG_IDX_W-1:0] rd, rs, rt;
  logic                 is_add, is_mul;
  assign op     = ir_q[OP_LSB +: OP_W];
  assign rd     = ir_q[RD_LSB +: REG_IDX_W];
  assign rs     = ir_q[RS_LSB +: REG_IDX_W];
  assign rt     = ir_q[RT_LSB +: REG_IDX_W];
  assign is_add = (op == OP_ADD) || (op == OP_SUB);
  assign is_mul = (op == OP_MUL);

  logic cdb_hit;
  assign cdb_hit = cdb_valid && (cdb_tag != TAG_0) && (int'(cdb_tag) <= N_RS);

  logic [DATA_W-1:0] rs_val, rt_val;
  logic [TAG_W-1:0]  rs_tag, rt_tag;
  logic              do_issue;
  logic              free_found;
  logic [TAG_W-1:0]  free_tag;

  reg_status_table #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) u_rst (
    .clk_i        (Clock),
    .rst_i        (Reset),
    .rs_idx_i     (rs),
    .rt_idx_i     (rt),
    .rs_val_o     (rs_val),
    .rs_tag_o     (rs_tag),
    .rt_val_o     (rt_val),
    .rt_tag_o     (rt_tag),
    .cdb_hit_i    (cdb_hit),
    .cdb_tag_i    (cdb_tag),
    .cdb_data_i   (cdb_data),
    .rename_en_i  (do_issue),
    .rename_idx_i (rd),
    .rename_tag_i (free_tag)
  );

  logic [N_RS-1:0] busy_post_cdb, busy_eff;

  // NOTE: every variable written here gets a default first so no path leaves it
  // unassigned, which would infer a latch; combinational blocks use blocking '='.
  always_comb begin
    busy_post_cdb = busy_q;
    for (int i = 0; i < N_RS; i++) begin
      if (cdb_hit && (cdb_tag == TAG_W'(i + 1))) busy_post_cdb[i] = 1'b0;
    end
    busy_eff = BYPASS_EN ? busy_post_cdb : busy_q;

    free_found = 1'b0;
    free_tag   = TAG_0;
    for (int i = 0; i < N_RS; i++) begin
      if (!free_found && !busy_eff[i] &&
          ((is_add && i < N_ADD_RS) || (is_mul && i >= N_ADD_RS))) begin
        free_found = 1'b1;
        free_tag   = TAG_W'(i + 1);
      end
    end

    do_issue = (state_q == S_ISSUE) && free_found;
    busy_d   = busy_post_cdb;
    for (int i = 0; i < N_RS; i++) begin
      if (do_issue && (free_tag == TAG_W'(i + 1))) busy_d[i] = 1'b1;
    end
  end

  logic [DATA_W-1:0] vj, vk;
  logic [TAG_W-1:0]  qj, qk;

  always_comb begin
    vj = rs_val;
    qj = TAG_0;
    if (rs_tag != TAG_0) begin
      vj = '0;
      qj = rs_tag;
      if (BYPASS_EN && cdb_hit && (rs_tag == cdb_tag)) begin
        vj = cdb_data;
        qj = TAG_0;
      end
    end
    vk = rt_val;
    qk = TAG_0;
    if (rt_tag != TAG_0) begin
      vk = '0;
      qk = rt_tag;
      if (BYPASS_EN && cdb_hit && (rt_tag == cdb_tag)) begin
        vk = cdb_data;
        qk = TAG_0;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= S_REQ;
      ir_q         <= '0;
      avaliable_q  <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_tag_q   <= '0;
      disp_op_q    <= '0;
      disp_vj_q    <= '0;
      disp_vk_q    <= '0;
      disp_qj_q    <= '0;
      disp_qk_q    <= '0;
      busy_q       <= '0;
    end else begin
      avaliable_q  <= 1'b0;
      disp_valid_q <= 1'b0;
      busy_q       <= busy_d;
      case (state_q)
        S_REQ: begin
          avaliable_q <= 1'b1;
          state_q     <= S_CAP;
        end
        S_CAP: begin
          // enable_in may be held high, so a word is taken only here.
          if (enable_in) begin
            ir_q    <= instruction_in[IR_W-1:0];
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!(is_add || is_mul)) begin
            state_q <= S_REQ;
          end else if (free_found) begin
            disp_valid_q <= 1'b1;
            disp_tag_q   <= free_tag;
            disp_op_q    <= op;
            disp_vj_q    <= vj;
            disp_vk_q    <= vk;
            disp_qj_q    <= qj;
            disp_qk_q    <= qk;
            state_q      <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

  assign avaliable  = avaliable_q;
  assign disp_valid = disp_valid_q;
  assign disp_tag   = disp_tag_q;
  assign disp_op    = disp_op_q;
  assign disp_vj    = disp_vj_q;
  assign disp_vk    = disp_vk_q;
  assign disp_qj    = disp_qj_q;
  assign disp_qk    = disp_qk_q;
  assign stall      = (state_q == S_ISSUE) && (is_add || is_mul) && !free_found;

endmodule

// File: tb/tb_tomasulo_issue_unit.sv
// Directed self-checking bench for tomasulo_issue_unit; a small queue model
// answers each avaliable request with the next word the test supplies.
module tb_tomasulo_issue_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        enable_in = 1'b0;
  logic [15:0] instruction_in = '0;
  logic        cdb_valid = 1'b0;
  logic [2:0]  cdb_tag = '0;
  logic [15:0] cdb_data = '0;
  logic        avaliable, disp_valid, stall;
  logic [2:0]  disp_tag, disp_qj, disp_qk;
  logic [3:0]  disp_op;
  logic [15:0] disp_vj, disp_vk;

  tomasulo_issue_unit dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .enable_in      (enable_in),
    .instruction_in (instruction_in),
    .avaliable      (avaliable),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_data       (cdb_data),
    .disp_valid     (disp_valid),
    .disp_tag       (disp_tag),
    .disp_op        (disp_op),
    .disp_vj        (disp_vj),
    .disp_vk        (disp_vk),
    .disp_qj        (disp_qj),
    .disp_qk        (disp_qk),
    .stall          (stall)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_err = 0;

  // Packet layout: {tag, op, vj, qj, vk, qk}
  logic [44:0] pkt;
  assign pkt = {disp_tag, disp_op, disp_vj, disp_qj, disp_vk, disp_qk};

  // Queue model: count requests seen at the edge, the bench serves them in order.
  int n_req = 0;
  int n_served = 0;
  always @(posedge Clock) begin
    if (Reset) n_req <= n_served;
    else if (avaliable) n_req <= n_req + 1;
  end

  task automatic do_reset();
    Reset = 1'b1; enable_in = 1'b0; cdb_valid = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b0;
  endtask

  task automatic issue_word(input logic [15:0] w);
    bit got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (n_req > n_served) begin got = 1'b1; break; end
      @(posedge Clock); #1;
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL issue_request_timeout: no avaliable request for word %h", w);
    end
    n_served++;
    enable_in = 1'b1; instruction_in = w;
    @(posedge Clock); #1;
    enable_in = 1'b0;
  endtask

  task automatic wait_disp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (disp_valid) begin ok = 1'b1; break; end
      @(posedge Clock); #1;
    end
  endtask

  task automatic pulse_cdb(input logic [2:0] t, input logic [15:0] d);
    cdb_valid = 1'b1; cdb_tag = t; cdb_data = d;
    @(posedge Clock); #1;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    n_cmp++; if (avaliable !== 1'b0) begin n_err++; $display("FAIL rst_avaliable: got %b want 0", avaliable); end
    n_cmp++; if (disp_valid !== 1'b0) begin n_err++; $display("FAIL rst_disp_valid: got %b want 0", disp_valid); end
    n_cmp++; if (pkt !== 45'd0) begin n_err++; $display("FAIL rst_disp_fields: got %h want 0", pkt); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", stall); end
    Reset = 1'b0;
    @(posedge Clock); #1;
    n_cmp++; if (avaliable !== 1'b1) begin n_err++; $display("FAIL rst_first_request: got %b want 1", avaliable); end
    @(posedge Clock); #1;
    n_cmp++; if (avaliable !== 1'b0) begin n_err++; $display("FAIL request_one_cycle: got %b want 0", avaliable); end
  endtask

  task automatic test_add_sub();
    bit ok;
    logic [44:0] exp;
    issue_word(16'h0CA0);  // ADD R3,R1,R2
    wait_disp(ok);
    exp = {3'd1, 4'd0, 16'd1, 3'd0, 16'd2, 3'd0};
    n_cmp++; if (!ok || pkt !== exp) begin n_err++; $display("FAIL add_pkt: valid=%b got %h want %h", ok, pkt, exp); end
    @(posedge Clock); #1;
    n_cmp++; if (disp_valid !== 1'b0) begin n_err++; $display("FAIL disp_pulse_width: got %b want 0", disp_valid); end
    issue_word(16'h1591);  // SUB R5,R3,R1: R3 renamed to tag 1
    wait_disp(ok);
    exp = {3'd2, 4'd1, 16'd0, 3'd1, 16'd1, 3'd0};
    n_cmp++; if (!ok || pkt !== exp) begin n_err++; $display("FAIL sub_pkt: valid=%b got %h want %h", ok, pkt, exp); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [44:0] exp;
    do_reset();
    for (int t = 1; t <= 3; t++) begin
      issue_word(16'h0CA0);
      wait_disp(ok);
      exp = {3'(t), 4'd0, 16'd1, 3'd0, 16'd2, 3'd0};
      n_cmp++; if (!ok || pkt !== exp) begin n_err++; $display("FAIL b2b_pkt%0d: valid=%b got %h want %h", t, ok, pkt, exp); end
    end
    issue_word(16'h0CA0);
    repeat (3) @(posedge Clock);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL b2b_stall: got %b want 1", stall); end
    n_cmp++; if (avaliable !== 1'b0) begin n_err++; $display("FAIL b2b_avaliable: got %b want 0", avaliable); end
    n_cmp++; if (disp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_no_disp: got %b want 0", disp_valid); end
    pulse_cdb(3'd2, 16'h1234);
    wait_disp(ok);
    exp = {3'd2, 4'd0, 16'd1, 3'd0, 16'd2, 3'd0};
    n_cmp++; if (!ok || pkt !== exp) begin n_err++; $display("FAIL b2b_realloc_pkt: valid=%b got %h want %h", ok, pkt, exp); end
    @(posedge Clock); #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL b2b_stall_release: got %b want 0", stall); end
  endtask

  task automatic test_nop();
    bit seen = 1'b0;
    bit got = 1'b0;
    issue_word(16'h0002);  // op 0010 is not an ALU op, pool is full anyway
    for (int i = 0; i < 4; i++) begin
      if (disp_valid || stall) seen = 1'b1;
      @(posedge Clock); #1;
    end
    n_cmp++; if (seen) begin n_err++; $display("FAIL nop_no_dispatch: got dispatch/stall=1 want 0"); end
    for (int i = 0; i < 6; i++) begin
      if (n_req > n_served) begin got = 1'b1; break; end
      @(posedge Clock); #1;
    end
    n_cmp++; if (!got) begin n_err++; $display("FAIL nop_rerequest: got no request want 1"); end
  endtask

  task automatic test_mul_cdb();
    bit ok;
    logic [44:0] exp;
    do_reset();
    issue_word(16'h14A0);  // ADD R5,R1,R2 -> tag 1
    wait_disp(ok);
    exp = {3'd1, 4'd0, 16'd1, 3'd0, 16'd2, 3'd0};
    n_cmp++; if (!ok || pkt !== exp) begin n_err++; $display("FAIL mul_add_pkt: valid=%b got %h want %h", ok, pkt, exp); end
    issue_word(16'h1AC4);  // MUL R6,R5,R4 -> tag 4, waits on tag 1
    wait_disp(ok);
    exp = {3'd4, 4'd4, 16'd0, 3'd1, 16'd4, 3'd0};
    n_cmp++; if (!ok || pkt !== exp) begin n_err++; $display("FAIL mul_pkt: valid=%b got %h want %h", ok, pkt, exp); end
    pulse_cdb(3'd0, 16'hBEEF);
    pulse_cdb(3'd7, 16'hDEAD);
    pulse_cdb(3'd1, 16'h0042);
    issue_word(16'h1EA0);  // ADD R7,R5,R2 -> tag 1 reused, R5=0x42, R2 untouched
    wait_disp(ok);
    exp = {3'd1, 4'd0, 16'h0042, 3'd0, 16'd2, 3'd0};
    n_cmp++; if (!ok || pkt !== exp) begin n_err++; $display("FAIL cdb_writeback_pkt: valid=%b got %h want %h", ok, pkt, exp); end
  endtask

  task automatic test_cdb_same_cycle();
    bit ok;
    logic [44:0] exp;
    do_reset();
    issue_word(16'h0CA0);  // ADD R3,R1,R2 -> tag 1
    wait_disp(ok);
    exp = {3'd1, 4'd0, 16'd1, 3'd0, 16'd2, 3'd0};
    n_cmp++; if (!ok || pkt !== exp) begin n_err++; $display("FAIL same_add_pkt: valid=%b got %h want %h", ok, pkt, exp); end
    issue_word(16'h1591);  // SUB R5,R3,R1 dispatching while tag 1 broadcasts
    pulse_cdb(3'd1, 16'h0077);
    wait_disp(ok);
`ifdef ISSUE_CDB_BYPASS_EN
    exp = {3'd1, 4'd1, 16'h0077, 3'd0, 16'd1, 3'd0};
`else
    exp = {3'd2, 4'd1, 16'd0, 3'd1, 16'd1, 3'd0};
`endif
    n_cmp++; if (!ok || pkt !== exp) begin n_err++; $display("FAIL same_sub_pkt: valid=%b got %h want %h", ok, pkt, exp); end
    issue_word(16'h1D80);  // ADD R7,R3,R0: R3 was written by the broadcast
    wait_disp(ok);
`ifdef ISSUE_CDB_BYPASS_EN
    exp = {3'd2, 4'd0, 16'h0077, 3'd0, 16'd0, 3'd0};
`else
    exp = {3'd1, 4'd0, 16'h0077, 3'd0, 16'd0, 3'd0};
`endif
    n_cmp++; if (!ok || pkt !== exp) begin n_err++; $display("FAIL same_after_pkt: valid=%b got %h want %h", ok, pkt, exp); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [44:0] exp;
    do_reset();
    for (int t = 1; t <= 3; t++) begin
      issue_word(16'h0CA0);
      wait_disp(ok);
    end
    issue_word(16'h0CA0);
    @(posedge Clock); #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL mid_pre_stall: got %b want 1", stall); end
    Reset = 1'b1;
    @(posedge Clock); #1;
    n_cmp++; if (avaliable !== 1'b0) begin n_err++; $display("FAIL mid_avaliable: got %b want 0", avaliable); end
    n_cmp++; if (disp_valid !== 1'b0) begin n_err++; $display("FAIL mid_disp_valid: got %b want 0", disp_valid); end
    n_cmp++; if (pkt !== 45'd0) begin n_err++; $display("FAIL mid_disp_fields: got %h want 0", pkt); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL mid_stall: got %b want 0", stall); end
    Reset = 1'b0;
    @(posedge Clock); #1;
    n_cmp++; if (avaliable !== 1'b1) begin n_err++; $display("FAIL mid_state_req: got %b want 1", avaliable); end
    issue_word(16'h1DC0);  // ADD R7,R3,R4 with fresh tables
    wait_disp(ok);
    exp = {3'd1, 4'd0, 16'd3, 3'd0, 16'd4, 3'd0};
    n_cmp++; if (!ok || pkt !== exp) begin n_err++; $display("FAIL mid_first_pkt: valid=%b got %h want %h", ok, pkt, exp); end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_back_to_back();
    test_nop();
    test_mul_cdb();
    test_cdb_same_cycle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
